tmds_channel_decoder: RTL and testbench
=======================================

// Module: tmds_channel_decoder
// PURPOSE
//  Receive-side counterpart of the DVI transmitter's per-channel 8b/10b TMDS encoder.
//  Takes one deserialized 10-bit TMDS symbol per pixel_clk and finds word alignment
//  by requesting bitslips. Decodes data symbols to 8-bit pixel data and control
//  tokens to c0/c1/de. Sits between the HDMI deserializer and channel deskew/video_rx logic.
// PARAMETERS
//  CTRL_RUN    8     consecutive control tokens needed to declare/refresh lock
//  SEARCH_WIN  4096  pixel_clk cycles allowed without a CTRL_RUN-long token run
//  SLIP_WAIT   16    cycles to wait after a bitslip pulse before searching again
// PORTS
//  pixel_clk  in   1   pixel clock; all logic in this clock domain
//  sys_rst_n  in   1   async active-low reset
//  sym_in     in   10  TMDS symbol from deserializer, one per cycle, bit0 first-serialized
//  bitslip    out  1   one-cycle pulse: deserializer shifts word boundary by one bit
//  locked     out  1   alignment achieved
//  de         out  1   data enable (data symbol decoded)
//  ctrl       out  2   {c1,c0} from last control token; held while de=1
//  data       out  8   decoded pixel byte; valid when de=1
//  err_cnt    out  16  lock-loss count (only with TMDS_ERR_CNT_EN)
// BEHAVIOUR
//  Reset (async, any time, incl. mid-slip): FSM=SEARCH; bitslip=0, locked=0, de=0,
//   ctrl=0, data=0, all counters 0. Takes effect immediately; released synchronously.
//  Pipeline: sym_in registered (stage1), decoded and registered to outputs (stage2).
//   Latency sym_in -> de/ctrl/data = 2 cycles. Throughput one symbol per cycle.
//  Token compare (stage1): 10'h354->00, 10'h0AB->01, 10'h154->10, 10'h2AB->11.
//  Data decode: d = sym[9] ? ~sym[7:0] : sym[7:0]; out[0]=d[0];
//   out[i] = sym[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]) for i=1..7.
//  Outputs while locked=0: de=0, data=0, ctrl=0 (stage2 gated by FSM state).
//  Outputs while locked=1: token -> de=0, ctrl=token, data=0.
//   Other symbol -> de=1, data=decoded value, ctrl holds.
//  run_cnt: +1 on token, 0 on non-token; saturates at CTRL_RUN.
//  win_cnt: +1 each cycle in SEARCH/LOCKED; cleared when run_cnt reaches CTRL_RUN.
//  FSM:
//   SEARCH: run_cnt==CTRL_RUN -> LOCKED (locked=1 next cycle).
//     Else win_cnt==SEARCH_WIN-1 -> bitslip=1 for one cycle, go SLIP.
//   SLIP: wait SLIP_WAIT cycles. run_cnt, win_cnt held at 0.
//     No second bitslip issued. Then -> SEARCH.
//   LOCKED: run_cnt==CTRL_RUN restarts win_cnt.
//     win_cnt==SEARCH_WIN-1 -> SEARCH, locked=0 next cycle. No bitslip on this exit.
//  Simultaneous run completion and window expiry in one cycle: run completion wins.
//  Counters sized $clog2(param+1). No wrap: each counter cleared before its limit.
// CONFIGURATION
//  TMDS_ERR_CNT_EN defined:
//   err_cnt port exists; +1 on each LOCKED->SEARCH transition.
//   Saturates at 16'hFFFF; cleared only by reset.
//  TMDS_ERR_CNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  tmds_pkg: the four control-token constants, FSM state encoding (SEARCH/SLIP/LOCKED).
//   Shared with the transmitter-side encoder.
//  Sub-module tmds_sym_decode: purely combinational 10b->8b decode plus is_ctrl/ctrl
//   outputs. Instanced once in stage1->stage2 path; FSM and counters stay in this module.
// TESTING
//  1 Aligned stream: 12x 10'h354, then encoder output of 8'hA5 -> locked=1 after the 8th token
//    is registered. Following data gives de=1, data=8'hA5, 2 cycles after its sym_in.
//  2 All four tokens 10'h354/0AB/154/2AB while locked -> de=0, ctrl=00/01/10/11.
//    Each appears 2 cycles after its token.
//  3 Stream rotated by 3 bits, deserializer model honours bitslip -> exactly 3 bitslip pulses,
//    at least SLIP_WAIT+1 cycles apart. Then locked=1 and data matches source.
//  4 Locked, then tokens withheld for SEARCH_WIN cycles -> locked falls, no bitslip at that exit,
//    err_cnt 0->1 with TMDS_ERR_CNT_EN. Resuming token runs relocks.
//  5 Assert sys_rst_n=0 during SLIP and during LOCKED -> all outputs 0 immediately.
//    After release, FSM in SEARCH.
//  6 7 tokens, one data symbol, 7 tokens -> no lock (run_cnt cleared).
//    An 8-token run afterwards locks.

Source files
------------

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS control-token constants and channel-decoder FSM states
// Shared between the transmit-side encoder and the receive-side channel decoder.
package tmds_pkg;

  localparam logic [9:0] TMDS_TOK_00 = 10'h354;
  localparam logic [9:0] TMDS_TOK_01 = 10'h0AB;
  localparam logic [9:0] TMDS_TOK_10 = 10'h154;
  localparam logic [9:0] TMDS_TOK_11 = 10'h2AB;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } tmds_state_t;

endpackage

// File: rtl/tmds_sym_decode.sv
// rtl/tmds_sym_decode.sv - combinational TMDS 10b symbol decode
// Produces the 8-bit data byte plus control-token detection and {c1,c0}.
module tmds_sym_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  logic [7:0] d;

  always_comb begin
    is_ctrl = 1'b1;
    ctrl    = 2'b00;
    case (sym)
      TMDS_TOK_00: ctrl = 2'b00;
      TMDS_TOK_01: ctrl = 2'b01;
      TMDS_TOK_10: ctrl = 2'b10;
      TMDS_TOK_11: ctrl = 2'b11;
      default:     is_ctrl = 1'b0;
    endcase
  end

  // bit 9 undoes DC-balance inversion, bit 8 selects XOR vs XNOR chaining
  assign d         = sym[9] ? ~sym[7:0] : sym[7:0];
  assign data[0]   = d[0];
  assign data[7:1] = sym[8] ? (d[7:1] ^ d[6:0]) : ~(d[7:1] ^ d[6:0]);

endmodule

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS channel word alignment and symbol decode
// Optional lock-loss counter on err_cnt when TMDS_ERR_CNT_EN is defined.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN   = 8,
  parameter int SEARCH_WIN = 4096,
  parameter int SLIP_WAIT  = 16
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  sym_in,
  output logic        bitslip,
  output logic        locked,
  output logic        de,
  output logic [1:0]  ctrl,
  output logic [7:0]  data
`ifdef TMDS_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int WIN_W  = $clog2(SEARCH_WIN + 1);
  localparam int SLIP_W = $clog2(SLIP_WAIT + 1);
  localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(CTRL_RUN);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WIN - 1);
  localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT - 1);

  // reset asserts immediately, deasserts on a clock edge
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [9:0] sym_q;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) sym_q <= '0;
    else        sym_q <= sym_in;
  end

  logic       dec_is_ctrl;
  logic [1:0] dec_ctrl;
  logic [7:0] dec_data;

  tmds_sym_decode u_dec (
    .sym     (sym_q),
    .is_ctrl (dec_is_ctrl),
    .ctrl    (dec_ctrl),
    .data    (dec_data)
  );

  tmds_state_t       state;
  logic [RUN_W-1:0]  run_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [SLIP_W-1:0] slip_cnt;
  logic              run_done;
  logic              win_done;
`ifdef TMDS_ERR_CNT_EN
  logic [15:0]       err_q;
  assign err_cnt = err_q;
`endif

  assign run_done = (run_cnt == RUN_FULL);
  assign win_done = (win_cnt == WIN_LAST);

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SEARCH;
      run_cnt  <= '0;
      win_cnt  <= '0;
      slip_cnt <= '0;
      bitslip  <= 1'b0;
      locked   <= 1'b0;
`ifdef TMDS_ERR_CNT_EN
      err_q    <= '0;
`endif
    end else begin
      bitslip <= 1'b0;
      if (state == ST_SLIP || !dec_is_ctrl) run_cnt <= '0;
      else if (!run_done)                   run_cnt <= run_cnt + RUN_W'(1);

      case (state)
        ST_SEARCH: begin
          // run completion takes priority over window expiry
          if (run_done) begin
            state   <= ST_LOCKED;
            locked  <= 1'b1;
            win_cnt <= '0;
          end else if (win_done) begin
            state    <= ST_SLIP;
            bitslip  <= 1'b1;
            win_cnt  <= '0;
            run_cnt  <= '0;
            slip_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
          end
        end
        ST_SLIP: begin
          win_cnt <= '0;
          if (slip_cnt == SLIP_LAST) begin
            state    <= ST_SEARCH;
            slip_cnt <= '0;
          end else begin
            slip_cnt <= slip_cnt + SLIP_W'(1);
          end
        end
        ST_LOCKED: begin
          if (run_done) begin
            win_cnt <= '0;
          end else if (win_done) begin
            state   <= ST_SEARCH;
            locked  <= 1'b0;
            win_cnt <= '0;
`ifdef TMDS_ERR_CNT_EN
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
`endif
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
          end
        end
        default: state <= ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      de   <= 1'b0;
      ctrl <= 2'b00;
      data <= 8'h00;
    end else if (state != ST_LOCKED) begin
      de   <= 1'b0;
      ctrl <= 2'b00;
      data <= 8'h00;
    end else if (dec_is_ctrl) begin
      de   <= 1'b0;
      ctrl <= dec_ctrl;
      data <= 8'h00;
    end else begin
      de   <= 1'b1;
      data <= dec_data;
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - scoreboard bench for tmds_channel_decoder
// Deserializer model rotates the serial stream and honours bitslip pulses.
`timescale 1ns/1ps
module tb_tmds_channel_decoder;

  localparam int SEARCH_WIN = 4096;
  localparam int SLIP_WAIT  = 16;
  localparam logic [9:0] T00 = 10'h354;

  typedef struct packed {
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
  } exp_t;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [9:0]  sym_in    = 10'h163;
  logic        bitslip, locked, de;
  logic [1:0]  ctrl;
  logic [7:0]  data;
`ifdef TMDS_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  tmds_channel_decoder #(
    .CTRL_RUN   (8),
    .SEARCH_WIN (SEARCH_WIN),
    .SLIP_WAIT  (SLIP_WAIT)
  ) dut (
    .pixel_clk (pixel_clk),
    .sys_rst_n (sys_rst_n),
    .sym_in    (sym_in),
    .bitslip   (bitslip),
    .locked    (locked),
    .de        (de),
    .ctrl      (ctrl),
    .data      (data)
`ifdef TMDS_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 pixel_clk = ~pixel_clk;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  logic chk_now = 1'b0;
  logic p0 = 1'b0, p1 = 1'b0;
  int   out_idx = 0;
  exp_t mon_e;

  int         s = 0;
  logic [9:0] prev_src = T00, cur_src = T00;
  int         slips = 0, cyc = 0, last_slip = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // one symbol per cycle, driven 1ns after the rising edge
  task automatic send(input logic [9:0] src, input logic chk, input exp_t e);
    logic [19:0] w;
    @(posedge pixel_clk);
    #1;
    cyc++;
    if (bitslip === 1'b1) begin
      if (last_slip >= 0) check("slip_gap", 32'(cyc - last_slip >= SLIP_WAIT + 1), 32'd1);
      slips++;
      last_slip = cyc;
      s = (s == 0) ? 9 : s - 1;
    end
    prev_src = cur_src;
    cur_src  = src;
    w        = {cur_src, prev_src} >> (10 - s);
    sym_in   = w[9:0];
    chk_now  = chk;
    if (chk) exp_q.push_back(e);
  endtask

  task automatic sendu(input logic [9:0] src);
    send(src, 1'b0, '0);
  endtask

  task automatic sendc(input logic [9:0] src, input logic e_de, input logic [1:0] e_ctrl,
                       input logic [7:0] e_data);
    send(src, 1'b1, {e_de, e_ctrl, e_data});
  endtask

  task automatic pulse_reset(input string tag, input int s_init);
    #1 sys_rst_n = 1'b0;
    #1 check(tag, 32'({bitslip, locked, de, ctrl, data}), 32'd0);
`ifdef TMDS_ERR_CNT_EN
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
`endif
    s         = s_init;
    last_slip = -1;
    #1 sys_rst_n = 1'b1;
    repeat (4) sendu(10'h163);
  endtask

  // outputs for a symbol appear two cycles after it is driven
  always @(negedge pixel_clk) begin
    if (p1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out#%0d: got output %0h, expected nothing queued", out_idx, {de, ctrl, data});
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("out#%0d", out_idx), 32'({de, ctrl, data}), 32'(mon_e));
      end
      out_idx++;
    end
    p1 = p0;
    p0 = chk_now;
  end

  logic [9:0] pat [12];

  initial begin
    int n;
    int s0;
    for (int i = 0; i < 10; i++) pat[i] = T00;
    pat[10] = 10'h163;
    pat[11] = 10'h2CA;

    repeat (3) sendu(10'h163);
    check("reset_outputs", 32'({bitslip, locked, de, ctrl, data}), 32'd0);
`ifdef TMDS_ERR_CNT_EN
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif
    sys_rst_n = 1'b1;
    repeat (4) sendu(10'h163);

    // aligned stream locks, then data decodes
    repeat (7) sendu(T00);
    check("t1_unlocked_after_7", 32'(locked), 32'd0);
    repeat (5) sendu(T00);
    check("t1_locked", 32'(locked), 32'd1);
    sendc(10'h163, 1'b1, 2'b00, 8'hA5);
    sendc(10'h2CA, 1'b1, 2'b00, 8'hA1);
    sendc(10'h100, 1'b1, 2'b00, 8'h00);
    sendc(10'h2FF, 1'b1, 2'b00, 8'hFE);
    sendc(10'h0FF, 1'b1, 2'b00, 8'hFF);

    // all four tokens, ctrl held across data
    sendc(10'h354, 1'b0, 2'b00, 8'h00);
    sendc(10'h0AB, 1'b0, 2'b01, 8'h00);
    sendc(10'h163, 1'b1, 2'b01, 8'hA5);
    sendc(10'h154, 1'b0, 2'b10, 8'h00);
    sendc(10'h2AB, 1'b0, 2'b11, 8'h00);
    sendc(10'h155, 1'b1, 2'b11, 8'hFF);
    repeat (10) sendu(T00);

    // tokens withheld: lock lost without bitslip
    s0 = slips;
    n  = 0;
    while (locked && n < SEARCH_WIN + 100) begin
      sendu(10'h163);
      n++;
    end
    check("t4_unlocked", 32'(locked), 32'd0);
    check("t4_unlock_time", 32'(n >= SEARCH_WIN - 2 && n <= SEARCH_WIN + 6), 32'd1);
    check("t4_no_bitslip", 32'(slips - s0), 32'd0);
`ifdef TMDS_ERR_CNT_EN
    check("t4_err_cnt", 32'(err_cnt), 32'd1);
`endif
    repeat (12) sendu(T00);
    check("t4_relock", 32'(locked), 32'd1);
    repeat (2) sendu(T00);

    // broken runs never lock
    pulse_reset("t6_reset", 0);
    repeat (7) sendu(T00);
    sendu(10'h163);
    repeat (7) sendu(T00);
    repeat (4) sendu(10'h163);
    check("t6_no_lock", 32'(locked), 32'd0);
    repeat (12) sendu(T00);
    check("t6_lock", 32'(locked), 32'd1);

    // reset while locked, then reset while in SLIP
    pulse_reset("t5_locked_reset", 0);
    s0 = slips;
    n  = 0;
    while (slips == s0 && n < SEARCH_WIN + 100) begin
      sendu(10'h163);
      n++;
    end
    check("t5_slip_seen", 32'(slips - s0), 32'd1);
    pulse_reset("t5_slip_reset", 0);
    repeat (12) sendu(T00);
    check("t5_search_after_reset", 32'(locked), 32'd1);
    repeat (2) sendu(T00);

    // stream rotated by 3 bits: three bitslips to align
    pulse_reset("t3_reset", 3);
    s0 = slips;
    n  = 0;
    while (!locked && n < 20000) begin
      sendu(pat[n % 12]);
      n++;
    end
    check("t3_locked", 32'(locked), 32'd1);
    check("t3_slip_count", 32'(slips - s0), 32'd3);
    sendc(10'h354, 1'b0, 2'b00, 8'h00);
    sendc(10'h163, 1'b1, 2'b00, 8'hA5);
    sendc(10'h2CA, 1'b1, 2'b00, 8'hA1);
    sendc(10'h0AB, 1'b0, 2'b01, 8'h00);
    sendc(10'h155, 1'b1, 2'b01, 8'hFF);
    repeat (4) sendu(T00);
    check("t3_no_extra_slip", 32'(slips - s0), 32'd3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
